// File: rtl/usb_rd_ctrl_if.sv
// Avalon-MM slave bus for the USB read sequencer: register access plus interrupt.
// The master modport is the CPU/fabric side; the slave modport is the sequencer.
interface usb_rd_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/usb_rd_ctrl.sv
// USB FIFO-chip read sequencer: watches RXF#, issues timed RD# pulses and buffers each byte
// in a local FIFO that the CPU drains through a zero-wait Avalon-MM slave.
module usb_rd_ctrl #(
    parameter int RD_CYCLES      = 4,
    parameter int RECOVER_CYCLES = 4,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    usb_rd_ctrl_if.slave  avl,
    input  logic          usb_rxf_n,
    input  logic [7:0]    usb_data,
    output logic          usb_rd_n
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int MAXC = (RD_CYCLES > RECOVER_CYCLES) ? RD_CYCLES : RECOVER_CYCLES;
    localparam int TW   = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, STROBE, RECOVER} state_t;

    state_t        state;
    logic [TW-1:0] tmr;
    logic          rxf_s1, rxf_s2;
    logic          enable, irq_en, irq_q;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          empty, full, busy;
    logic          push, pop, ctrl_wr, flush;
    logic [31:0]   rd_data;
    logic          wdata_unused;

    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign busy    = (state != IDLE);
    assign push    = (state == STROBE) && (tmr == TW'(RD_CYCLES - 1));
    assign pop     = avl.chipselect && !avl.read_n && (avl.address == 2'd0) && !empty;
    assign ctrl_wr = avl.chipselect && !avl.write_n && (avl.address == 2'd2);
    assign flush   = ctrl_wr && avl.writedata[2];
    assign wdata_unused = ^avl.writedata[31:3];

    // RXF# is asynchronous to clk; resets to the "no data" level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rxf_s1 <= 1'b1;
            rxf_s2 <= 1'b1;
        end else begin
            rxf_s1 <= usb_rxf_n;
            rxf_s2 <= rxf_s1;
        end
    end

    // Strobe sequencer: the full check at start time is what guarantees the later push fits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            tmr      <= '0;
            usb_rd_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (enable && !rxf_s2 && !full) begin
                        state    <= STROBE;
                        tmr      <= '0;
                        usb_rd_n <= 1'b0;
                    end
                end
                STROBE: begin
                    if (tmr == TW'(RD_CYCLES - 1)) begin
                        state    <= RECOVER;
                        tmr      <= '0;
                        usb_rd_n <= 1'b1;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                RECOVER: begin
                    if (tmr == TW'(RECOVER_CYCLES - 1)) begin
                        state <= IDLE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    tmr      <= '0;
                    usb_rd_n <= 1'b1;
                end
            endcase
        end
    end

    // FIFO bookkeeping; flush overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= usb_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable <= 1'b0;
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                enable <= avl.writedata[0];
                irq_en <= avl.writedata[1];
            end
            irq_q <= irq_en && !empty;
        end
    end

    always_comb begin
        rd_data = '0;
        case (avl.address)
            2'd0:    if (!empty) rd_data = {23'b0, 1'b1, mem[rd_ptr]};
            2'd1:    rd_data = ((32'(count) << 8) & 32'h0000_FF00)
                             | {28'b0, busy, full, empty, !rxf_s2};
            2'd2:    rd_data = {30'b0, irq_en, enable};
            default: rd_data = '0;
        endcase
    end

    assign avl.readdata = rd_data;
    assign avl.irq      = irq_q;
endmodule

// File: tb/tb_usb_rd_ctrl.sv
// Bench for usb_rd_ctrl: register table, directed strobe/FIFO sequences, and a randomized
// run checked against a queue-based model of the chip and FIFO.
module tb_usb_rd_ctrl;
    localparam int RD_CYCLES      = 4;
    localparam int RECOVER_CYCLES = 4;
    localparam int FIFO_DEPTH     = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       usb_rxf_n;
    logic [7:0] usb_data;
    logic       usb_rd_n;

    usb_rd_ctrl_if bus();

    usb_rd_ctrl #(
        .RD_CYCLES(RD_CYCLES),
        .RECOVER_CYCLES(RECOVER_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .avl(bus),
        .usb_rxf_n(usb_rxf_n),
        .usb_data(usb_data),
        .usb_rd_n(usb_rd_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int falls  = 0;

    always @(negedge usb_rd_n) if (reset_n === 1'b1) falls++;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        bus.chipselect = 1'b0;
        bus.read_n     = 1'b1;
        bus.write_n    = 1'b1;
        bus.address    = 2'd0;
        bus.writedata  = 32'h0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.read_n     = 1'b0;
        bus.address    = a;
        #1;
        d = bus.readdata;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        bus.address    = a;
        bus.writedata  = d;
        @(posedge clk);
        #1;
        bus_idle();
    endtask

    task automatic wait_rd(input logic lvl, input int bound, input string name);
        int n = 0;
        while (usb_rd_n !== lvl && n < bound) begin
            tick();
            n++;
        end
        check(name, 32'(usb_rd_n), 32'(lvl));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        usb_rxf_n = 1'b1;
        usb_data  = 8'h00;
        bus_idle();
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        int n, f0;

        tbl[0]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0002, "status_rst"};
        tbl[1]  = '{1'b0, 2'd0, 32'h0,         32'h0,         "data_empty"};
        tbl[2]  = '{1'b0, 2'd2, 32'h0,         32'h0,         "ctrl_rst"};
        tbl[3]  = '{1'b0, 2'd3, 32'h0,         32'h0,         "rsvd_rst"};
        tbl[4]  = '{1'b1, 2'd2, 32'h3,         32'h0,         "wr_ctrl"};
        tbl[5]  = '{1'b0, 2'd2, 32'h0,         32'h3,         "ctrl_rw"};
        tbl[6]  = '{1'b1, 2'd2, 32'h7,         32'h0,         "wr_flush"};
        tbl[7]  = '{1'b0, 2'd2, 32'h0,         32'h3,         "ctrl_flush_reads0"};
        tbl[8]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0,         "wr_status"};
        tbl[9]  = '{1'b0, 2'd1, 32'h0,         32'h0000_0002, "status_ro"};
        tbl[10] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0,         "wr_rsvd"};
        tbl[11] = '{1'b0, 2'd3, 32'h0,         32'h0,         "rsvd_ro"};
        tbl[12] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0,         "wr_data"};
        tbl[13] = '{1'b0, 2'd0, 32'h0,         32'h0,         "data_ro"};
        tbl[14] = '{1'b1, 2'd2, 32'h0,         32'h0,         "wr_ctrl_clr"};
        tbl[15] = '{1'b0, 2'd2, 32'h0,         32'h0,         "ctrl_clr"};

        // T1: reset state and register map
        do_reset();
        check("rst_rd_n", 32'(usb_rd_n), 32'h1);
        check("rst_irq", 32'(bus.irq), 32'h0);
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) reg_write(tbl[i].addr, tbl[i].wdata);
            else begin
                reg_read(tbl[i].addr, d);
                check(tbl[i].name, d, tbl[i].exp);
            end
        end
        check("t1_no_strobe", 32'(falls), 32'h0);

        // T2: single byte
        usb_data = 8'hA5;
        reg_write(2'd2, 32'h1);
        f0 = falls;
        usb_rxf_n = 1'b0;
        wait_rd(1'b0, 20, "t2_fall");
        n = 0;
        while (usb_rd_n === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        check("t2_width", 32'(n), 32'(RD_CYCLES));
        usb_rxf_n = 1'b1;
        reg_read(2'd1, d);
        check("t2_status", d & 32'h0000_FF06, 32'h0000_0100);
        reg_read(2'd0, d);
        check("t2_data", d, 32'h0000_01A5);
        repeat (10) tick();
        reg_read(2'd1, d);
        check("t2_empty", d, 32'h0000_0002);
        check("t2_one_strobe", 32'(falls - f0), 32'h1);

        // T3: fill to full, then one pop allows exactly one more strobe
        reg_write(2'd2, 32'h5);
        f0 = falls;
        usb_rxf_n = 1'b0;
        repeat (16 * (RD_CYCLES + RECOVER_CYCLES + 1) + 30) begin
            usb_data = 8'($urandom);
            tick();
        end
        check("t3_strobes", 32'(falls - f0), 32'd16);
        reg_read(2'd1, d);
        check("t3_full", d & 32'h0000_FF06, 32'h0000_1004);
        check("t3_rd_high", 32'(usb_rd_n), 32'h1);
        reg_read(2'd0, d);
        check("t3_pop_valid", d & 32'h0000_0100, 32'h0000_0100);
        repeat (30) tick();
        check("t3_refill", 32'(falls - f0), 32'd17);
        reg_read(2'd1, d);
        check("t3_full_again", d & 32'h0000_FF06, 32'h0000_1004);
        usb_rxf_n = 1'b1;
        repeat (6) tick();
        reg_write(2'd2, 32'h5);

        // T4: pop on the push edge keeps count, order preserved
        usb_data = 8'h01;
        usb_rxf_n = 1'b0;
        wait_rd(1'b0, 30, "t4_fall1");
        wait_rd(1'b1, 30, "t4_rise1");
        usb_data = 8'h02;
        wait_rd(1'b0, 30, "t4_fall2");
        repeat (RD_CYCLES - 1) tick();
        check("t4_pre_push", 32'(usb_rd_n), 32'h0);
        reg_read(2'd0, d);
        check("t4_pop_head", d, 32'h0000_0101);
        check("t4_push_edge", 32'(usb_rd_n), 32'h1);
        usb_data = 8'h03;
        reg_read(2'd1, d);
        check("t4_count_same", d & 32'h0000_FF00, 32'h0000_0100);
        wait_rd(1'b0, 30, "t4_fall3");
        wait_rd(1'b1, 30, "t4_rise3");
        usb_rxf_n = 1'b1;
        reg_read(2'd0, d);
        check("t4_byte2", d, 32'h0000_0102);
        reg_read(2'd0, d);
        check("t4_byte3", d, 32'h0000_0103);
        reg_read(2'd0, d);
        check("t4_drained", d, 32'h0);
        repeat (8) tick();

        // T5: disable during the strobe
        reg_write(2'd2, 32'h5);
        usb_data = 8'h5C;
        usb_rxf_n = 1'b0;
        wait_rd(1'b0, 30, "t5_fall");
        f0 = falls;
        n = 1;
        reg_write(2'd2, 32'h0);
        while (usb_rd_n === 1'b0 && n < 20) begin
            n++;
            tick();
        end
        check("t5_width", 32'(n), 32'(RD_CYCLES));
        repeat (30) tick();
        check("t5_no_more", 32'(falls - f0), 32'h0);
        reg_read(2'd1, d);
        check("t5_count", d & 32'h0000_FF06, 32'h0000_0100);
        reg_read(2'd0, d);
        check("t5_data", d, 32'h0000_015C);
        usb_rxf_n = 1'b1;
        repeat (4) tick();

        // T6: flush with five bytes stored drops irq
        reg_write(2'd2, 32'h7);
        usb_data = 8'h33;
        usb_rxf_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wait_rd(1'b0, 30, "t6_fall");
            wait_rd(1'b1, 30, "t6_rise");
        end
        usb_rxf_n = 1'b1;
        reg_read(2'd1, d);
        check("t6_count5", d & 32'h0000_FF06, 32'h0000_0500);
        check("t6_irq_on", 32'(bus.irq), 32'h1);
        reg_write(2'd2, 32'h7);
        reg_read(2'd1, d);
        check("t6_flushed", d & 32'h0000_FF06, 32'h0000_0002);
        check("t6_irq_off", 32'(bus.irq), 32'h0);

        // T6: reset asserted during a strobe
        reg_write(2'd2, 32'h1);
        usb_rxf_n = 1'b0;
        wait_rd(1'b0, 30, "t6r_fall");
        reset_n = 1'b0;
        #1;
        check("t6r_rd_high", 32'(usb_rd_n), 32'h1);
        usb_rxf_n = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        reg_read(2'd1, d);
        check("t6r_status", d, 32'h0000_0002);
        reg_read(2'd0, d);
        check("t6r_data", d, 32'h0);
        reg_read(2'd2, d);
        check("t6r_ctrl", d, 32'h0);

        // Randomized run against a chip + FIFO queue model
        begin
            logic [7:0] q [$];
            logic [7:0] cur_byte;
            logic       rd_prev, rd_now;
            int         low_cnt, high_cnt, pre, act, rp, r;
            bit         prev_nonempty;

            do_reset();
            reg_write(2'd2, 32'h3);
            tick();
            cur_byte      = 8'($urandom);
            usb_data      = cur_byte;
            rd_prev       = usb_rd_n;
            low_cnt       = 0;
            high_cnt      = 100;
            prev_nonempty = 1'b0;

            for (int cyc = 0; cyc < 3000; cyc++) begin
                rp = (cyc < 1200) ? 1 : 8;
                r  = int'($urandom_range(0, 19));
                if (r < rp) act = 1;
                else if (r == 19) act = 2;
                else if (r == 18 && $urandom_range(0, 9) == 0) act = 3;
                else act = 0;
                usb_rxf_n = ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0;

                case (act)
                    1: begin bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd0; end
                    2: begin bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.address = 2'd1; end
                    3: begin
                        bus.chipselect = 1'b1; bus.write_n = 1'b0;
                        bus.address = 2'd2; bus.writedata = 32'h7;
                    end
                    default: bus_idle();
                endcase
                #1;
                d   = bus.readdata;
                pre = q.size();
                if (act == 1)
                    check("rnd_data", d, (pre != 0) ? {23'b0, 1'b1, q[0]} : 32'h0);
                if (act == 2)
                    check("rnd_status", d & 32'h0000_FF06,
                          32'((pre << 8) | ((pre == 0) ? 2 : 0) | ((pre == FIFO_DEPTH) ? 4 : 0)));
                check("rnd_irq", 32'(bus.irq), 32'(prev_nonempty));

                @(posedge clk);
                #1;
                bus_idle();
                if (act == 1 && pre != 0) void'(q.pop_front());
                rd_now = usb_rd_n;
                if (rd_prev && !rd_now) begin
                    check("rnd_gap_ok", 32'(high_cnt >= RECOVER_CYCLES + 1), 32'h1);
                    low_cnt = 1;
                end else if (!rd_prev && rd_now) begin
                    check("rnd_width", 32'(low_cnt), 32'(RD_CYCLES));
                    high_cnt = 1;
                    if (act != 3) begin
                        q.push_back(cur_byte);
                        check("rnd_no_overflow", 32'(q.size() <= FIFO_DEPTH), 32'h1);
                    end
                    cur_byte = 8'($urandom);
                    usb_data = cur_byte;
                end else if (rd_now) begin
                    high_cnt++;
                end else begin
                    low_cnt++;
                end
                if (act == 3) q.delete();
                prev_nonempty = (pre != 0);
                rd_prev = rd_now;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
